// File: rtl/linreg_pkg.sv
// Shared definitions for the Q24.8 linear-regression datapath.
//   FRACT_BITS : fractional bits of every fixed-point quantity
//   Q24_8_W    : width of a sample operand (signed Q24.8)
//   Q47_8_W    : width of a rescaled product (signed Q47.8)
//   state_t    : frame-control FSM states
//   add_wraps  : signed two's-complement wrap detector for one addition
package linreg_pkg;

    localparam int FRACT_BITS = 8;
    localparam int Q24_8_W    = 32;
    localparam int Q47_8_W    = 56;

    typedef enum logic [1:0] {RUN, DRAIN1, DRAIN2, DONE} state_t;

    // An addition wrapped when both operands share a sign and the result does not.
    function automatic logic add_wraps(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/fixed_64_mult.sv
// Combinational signed Q24.8 x Q24.8 multiplier with Q47.8 result.
//   a, b : signed Q24.8 operands
//   p    : signed Q47.8 product (full 64-bit product rescaled by FRACT_BITS,
//          truncated toward minus infinity)
//   ovf  : product is not representable in the Q24.8 operand format, i.e. the
//          result has left the native sample range
module fixed_64_mult
    import linreg_pkg::*;
(
    input  logic [Q24_8_W-1:0] a,
    input  logic [Q24_8_W-1:0] b,
    output logic [Q47_8_W-1:0] p,
    output logic               ovf
);

    logic signed [2*Q24_8_W-1:0] full;

    assign full = (2*Q24_8_W)'($signed(a)) * (2*Q24_8_W)'($signed(b));
    assign p    = Q47_8_W'(full >>> FRACT_BITS);

    // Fits in Q24.8 only if every bit above the Q24.8 sign bit copies it.
    assign ovf  = (p[Q47_8_W-1:Q24_8_W-1] != {(Q47_8_W-Q24_8_W+1){p[Q24_8_W-1]}});

endmodule

// File: rtl/linreg_sum_accum.sv
// Streaming sufficient-statistics accumulator for the Q24.8 linear regressor.
// Collects n, sum(x), sum(y), sum(x*x), sum(x*y) over a frame ended by s_last
// and hands the totals to the slope/intercept solver.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous frame abort, zeroes all state
//   s_valid/s_ready     : sample handshake, s_x/s_y signed Q24.8, s_last ends frame
//   m_valid/m_ready     : result handshake
//   m_n                 : sample count (saturating)
//   m_sum_x, m_sum_y    : signed Q(SUM_W-8).8 sums
//   m_sum_xx, m_sum_xy  : signed Q(PSUM_W-8).8 sums of products
//   m_ovf               : sticky overflow (multiplier, accumulator wrap, count saturation)
// Pipeline for a sample accepted at edge k: input register at k, products at
// k+1, accumulators at k+2, result valid after k+3.
module linreg_sum_accum
    import linreg_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int SUM_W  = 48,
    parameter int PSUM_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_x,
    input  logic [31:0]       s_y,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  m_n,
    output logic [SUM_W-1:0]  m_sum_x,
    output logic [SUM_W-1:0]  m_sum_y,
    output logic [PSUM_W-1:0] m_sum_xx,
    output logic [PSUM_W-1:0] m_sum_xy,
    output logic              m_ovf
);

    state_t state;

    logic                s_take;
    logic                s0_valid, s0_last;
    logic [Q24_8_W-1:0]  s0_x, s0_y;
    logic [Q47_8_W-1:0]  mul_xx, mul_xy;
    logic                mul_ovf_xx, mul_ovf_xy;
    logic                st1_valid, st1_ovf;
    logic [Q24_8_W-1:0]  st1_x, st1_y;
    logic [Q47_8_W-1:0]  st1_xx, st1_xy;

    logic [SUM_W-1:0]    x_ext, y_ext, sum_x_nxt, sum_y_nxt;
    logic [PSUM_W-1:0]   xx_ext, xy_ext, sum_xx_nxt, sum_xy_nxt;
    logic                cnt_sat, step_ovf;
    logic                result_taken;

    // A sample offered together with clear is dropped.
    assign s_take       = s_valid && s_ready && !clear;
    assign result_taken = m_valid && m_ready;

    // ---------------- input register ----------------
    // NOTE: pipeline data registers are reset along with their valid bits so
    // that clear and rst_n leave no stale operands anywhere in the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_last  <= 1'b0;
            s0_x     <= '0;
            s0_y     <= '0;
        end else if (clear) begin
            s0_valid <= 1'b0;
            s0_last  <= 1'b0;
            s0_x     <= '0;
            s0_y     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register samples pre-edge values regardless of statement order.
            s0_valid <= s_take;
            if (s_take) begin
                s0_last <= s_last;
                s0_x    <= s_x;
                s0_y    <= s_y;
            end
        end
    end

    // ---------------- multipliers ----------------
    fixed_64_mult u_mult_xx (
        .a   (s0_x),
        .b   (s0_x),
        .p   (mul_xx),
        .ovf (mul_ovf_xx)
    );

    fixed_64_mult u_mult_xy (
        .a   (s0_x),
        .b   (s0_y),
        .p   (mul_xy),
        .ovf (mul_ovf_xy)
    );

    // ---------------- stage 1 ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st1_valid <= 1'b0;
            st1_ovf   <= 1'b0;
            st1_x     <= '0;
            st1_y     <= '0;
            st1_xx    <= '0;
            st1_xy    <= '0;
        end else if (clear) begin
            st1_valid <= 1'b0;
            st1_ovf   <= 1'b0;
            st1_x     <= '0;
            st1_y     <= '0;
            st1_xx    <= '0;
            st1_xy    <= '0;
        end else begin
            st1_valid <= s0_valid;
            if (s0_valid) begin
                st1_ovf <= mul_ovf_xx | mul_ovf_xy;
                st1_x   <= s0_x;
                st1_y   <= s0_y;
                st1_xx  <= mul_xx;
                st1_xy  <= mul_xy;
            end
        end
    end

    // ---------------- stage 2: accumulate ----------------
    assign x_ext  = {{(SUM_W-Q24_8_W){st1_x[Q24_8_W-1]}}, st1_x};
    assign y_ext  = {{(SUM_W-Q24_8_W){st1_y[Q24_8_W-1]}}, st1_y};
    assign xx_ext = {{(PSUM_W-Q47_8_W){st1_xx[Q47_8_W-1]}}, st1_xx};
    assign xy_ext = {{(PSUM_W-Q47_8_W){st1_xy[Q47_8_W-1]}}, st1_xy};
    assign cnt_sat = &m_n;

    // NOTE: every output of this block is assigned unconditionally first, so no
    // path leaves a value held and no latch is inferred.
    always_comb begin
        sum_x_nxt  = m_sum_x  + x_ext;
        sum_y_nxt  = m_sum_y  + y_ext;
        sum_xx_nxt = m_sum_xx + xx_ext;
        sum_xy_nxt = m_sum_xy + xy_ext;
        step_ovf   = st1_ovf | cnt_sat;
        if (add_wraps(m_sum_x[SUM_W-1],   x_ext[SUM_W-1],   sum_x_nxt[SUM_W-1]))   step_ovf = 1'b1;
        if (add_wraps(m_sum_y[SUM_W-1],   y_ext[SUM_W-1],   sum_y_nxt[SUM_W-1]))   step_ovf = 1'b1;
        if (add_wraps(m_sum_xx[PSUM_W-1], xx_ext[PSUM_W-1], sum_xx_nxt[PSUM_W-1])) step_ovf = 1'b1;
        if (add_wraps(m_sum_xy[PSUM_W-1], xy_ext[PSUM_W-1], sum_xy_nxt[PSUM_W-1])) step_ovf = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n      <= '0;
            m_sum_x  <= '0;
            m_sum_y  <= '0;
            m_sum_xx <= '0;
            m_sum_xy <= '0;
            m_ovf    <= 1'b0;
        end else if (clear || result_taken) begin
            m_n      <= '0;
            m_sum_x  <= '0;
            m_sum_y  <= '0;
            m_sum_xx <= '0;
            m_sum_xy <= '0;
            m_ovf    <= 1'b0;
        end else if (st1_valid) begin
            // Count sticks at its maximum; later samples still reach the sums.
            if (!cnt_sat) m_n <= m_n + CNT_W'(1);
            m_sum_x  <= sum_x_nxt;
            m_sum_y  <= sum_y_nxt;
            m_sum_xx <= sum_xx_nxt;
            m_sum_xy <= sum_xy_nxt;
            m_ovf    <= m_ovf | step_ovf;
        end
    end

    // ---------------- frame control ----------------
    // s_ready drops on the very edge that accepts the last sample; the FSM
    // then follows that sample down the pipeline (DRAIN1 while it is in stage 1,
    // DRAIN2 while it is accumulated) and raises m_valid once the sums are final.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
        end else if (clear) begin
            state   <= RUN;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (s_take && s_last) s_ready <= 1'b0;
                    if (s0_valid && s0_last) state <= DRAIN1;
                end
                DRAIN1: state <= DRAIN2;
                DRAIN2: begin
                    state   <= DONE;
                    m_valid <= 1'b1;
                end
                DONE: begin
                    if (m_ready) begin
                        state   <= RUN;
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_linreg_sum_accum.sv
// Self-checking bench for linreg_sum_accum: a reference model builds the
// expected frame totals as samples are driven and queues them; each result
// the DUT presents is popped and compared field by field.
module tb_linreg_sum_accum;

    localparam int CNT_W  = 16;
    localparam int SUM_W  = 48;
    localparam int PSUM_W = 64;

    logic              clk, rst_n, clear;
    logic              s_valid, s_ready, s_last;
    logic [31:0]       s_x, s_y;
    logic              m_valid, m_ready;
    logic [CNT_W-1:0]  m_n;
    logic [SUM_W-1:0]  m_sum_x, m_sum_y;
    logic [PSUM_W-1:0] m_sum_xx, m_sum_xy;
    logic              m_ovf;

    linreg_sum_accum #(.CNT_W(CNT_W), .SUM_W(SUM_W), .PSUM_W(PSUM_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_x      (s_x),
        .s_y      (s_y),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_n      (m_n),
        .m_sum_x  (m_sum_x),
        .m_sum_y  (m_sum_y),
        .m_sum_xx (m_sum_xx),
        .m_sum_xy (m_sum_xy),
        .m_ovf    (m_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0]  n;
        logic [SUM_W-1:0]  sx;
        logic [SUM_W-1:0]  sy;
        logic [PSUM_W-1:0] sxx;
        logic [PSUM_W-1:0] sxy;
        logic              ovf;
    } res_t;

    res_t exp_q[$];
    res_t mdl;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic mdl_reset();
        mdl = '{n: '0, sx: '0, sy: '0, sxx: '0, sxy: '0, ovf: 1'b0};
    endtask

    // Reference product: exact 64-bit product, rescaled, range-tested against Q24.8.
    function automatic logic [55:0] mdl_mul(input logic [31:0] a, input logic [31:0] b, output bit ov);
        longint fa, fb, pr;
        fa = longint'($signed(a));
        fb = longint'($signed(b));
        pr = (fa * fb) >>> 8;
        ov = (pr > 64'sd2147483647) || (pr < -64'sd2147483648);
        return pr[55:0];
    endfunction

    // Reference accumulate: add in 72 bits, flag ovf when the exact sum does not fit.
    task automatic mdl_add(input logic [31:0] x, input logic [31:0] y);
        logic [55:0]       pxx, pxy;
        bit                oxx, oxy;
        logic signed [71:0] w;
        pxx = mdl_mul(x, x, oxx);
        pxy = mdl_mul(x, y, oxy);
        if (oxx || oxy) mdl.ovf = 1'b1;
        if (mdl.n == {CNT_W{1'b1}}) mdl.ovf = 1'b1;
        else mdl.n = mdl.n + 16'd1;
        w = 72'($signed(mdl.sx)) + 72'($signed(x));
        if (w != 72'($signed(w[SUM_W-1:0]))) mdl.ovf = 1'b1;
        mdl.sx = w[SUM_W-1:0];
        w = 72'($signed(mdl.sy)) + 72'($signed(y));
        if (w != 72'($signed(w[SUM_W-1:0]))) mdl.ovf = 1'b1;
        mdl.sy = w[SUM_W-1:0];
        w = 72'($signed(mdl.sxx)) + 72'($signed(pxx));
        if (w != 72'($signed(w[PSUM_W-1:0]))) mdl.ovf = 1'b1;
        mdl.sxx = w[PSUM_W-1:0];
        w = 72'($signed(mdl.sxy)) + 72'($signed(pxy));
        if (w != 72'($signed(w[PSUM_W-1:0]))) mdl.ovf = 1'b1;
        mdl.sxy = w[PSUM_W-1:0];
    endtask

    // Drive one sample; returns #1 after its handshake edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic last);
        int w = 0;
        s_valid = 1'b1;
        s_x     = x;
        s_y     = y;
        s_last  = last;
        while (!s_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!s_ready) check("s_ready_timeout", {63'd0, s_ready}, 64'd1);
        @(posedge clk); #1;
        mdl_add(x, y);
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (last) begin
            exp_q.push_back(mdl);
            mdl_reset();
        end
    endtask

    // Wait for a result, compare it (optionally latency and stability), then accept it.
    task automatic get_result(input string tag, input int exp_lat, input int hold);
        int   lat = 0;
        res_t e;
        while (!m_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!m_valid) begin
            check({tag, "_timeout"}, {63'd0, m_valid}, 64'd1);
            return;
        end
        if (exp_lat > 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        for (int c = 0; c <= hold; c++) begin
            check({tag, "_n"},   64'(m_n),      64'(e.n));
            check({tag, "_sx"},  64'(m_sum_x),  64'(e.sx));
            check({tag, "_sy"},  64'(m_sum_y),  64'(e.sy));
            check({tag, "_sxx"}, m_sum_xx,      e.sxx);
            check({tag, "_sxy"}, m_sum_xy,      e.sxy);
            check({tag, "_ovf"}, {63'd0, m_ovf}, {63'd0, e.ovf});
            if (hold > 0) begin
                check({tag, "_hold_valid"}, {63'd0, m_valid}, 64'd1);
                check({tag, "_hold_ready"}, {63'd0, s_ready}, 64'd0);
            end
            if (c < hold) begin
                @(posedge clk); #1;
            end
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check({tag, "_after_valid"}, {63'd0, m_valid}, 64'd0);
        check({tag, "_after_ready"}, {63'd0, s_ready}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        s_x = '0; s_y = '0; m_ready = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_s_ready", {63'd0, s_ready}, 64'd1);
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_n_cnt",   64'(m_n), 64'd0);
        check("rst_sum_x",   64'(m_sum_x), 64'd0);
        check("rst_sum_xx",  m_sum_xx, 64'd0);
        check("rst_ovf",     {63'd0, m_ovf}, 64'd0);

        // 1: three unit samples back to back, latency 3 after last edge
        for (int i = 0; i < 3; i++) send(32'h100, 32'h200, i == 2);
        get_result("t1", 3, 0);

        // 2: negative x
        send(32'hFFFF_FE80, 32'h200, 1'b0);
        send(32'hFFFF_FE80, 32'h200, 1'b1);
        get_result("t2", 3, 0);

        // 3: multiplier overflow on x*x
        send(32'h7FFF_FFFF, 32'h100, 1'b1);
        get_result("t3", 3, 0);

        // 4: result held under back-pressure for 5 cycles
        send(32'h0000_0180, 32'hFFFF_FF00, 1'b0);
        send(32'h0000_0040, 32'h0000_0300, 1'b1);
        get_result("t4", 3, 5);

        // 5: clear mid-frame (with a sample offered in the clear cycle), then 1-sample frame
        send(32'h200, 32'h300, 1'b0);
        send(32'h400, 32'h500, 1'b0);
        clear = 1'b1; s_valid = 1'b1; s_x = 32'h900; s_y = 32'h900;
        @(posedge clk); #1;
        clear = 1'b0; s_valid = 1'b0;
        mdl_reset();
        check("t5_clear_n",     64'(m_n), 64'd0);
        check("t5_clear_ready", {63'd0, s_ready}, 64'd1);
        repeat (3) @(posedge clk);
        #1 check("t5_drop_n", 64'(m_n), 64'd0);
        send(32'h100, 32'h100, 1'b1);
        get_result("t5", 3, 0);

        // clear while the result is offered and m_ready=1: result discarded
        send(32'h300, 32'h100, 1'b1);
        for (int w = 0; w < 20 && !m_valid; w++) begin
            @(posedge clk); #1;
        end
        check("tc_valid", {63'd0, m_valid}, 64'd1);
        clear = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; m_ready = 1'b0;
        void'(exp_q.pop_front());
        check("tc_after_valid", {63'd0, m_valid}, 64'd0);
        check("tc_after_n",     64'(m_n), 64'd0);
        check("tc_after_ready", {63'd0, s_ready}, 64'd1);

        // 6: asynchronous reset during DRAIN1 of a 3-sample frame
        for (int i = 0; i < 3; i++) send(32'h100, 32'h100, i == 2);
        @(posedge clk); #1;
        check("t6_partial_n", 64'(m_n), 64'd2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {63'd0, m_valid}, 64'd0);
        check("t6_rst_ready", {63'd0, s_ready}, 64'd1);
        #2 rst_n = 1'b1;
        exp_q.delete();
        mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        check("t6_n",      64'(m_n), 64'd0);
        check("t6_sum_x",  64'(m_sum_x), 64'd0);
        check("t6_sum_y",  64'(m_sum_y), 64'd0);
        check("t6_sum_xx", m_sum_xx, 64'd0);
        check("t6_sum_xy", m_sum_xy, 64'd0);
        check("t6_valid",  {63'd0, m_valid}, 64'd0);

        // Post-reset frame still works
        send(32'hFFFF_FF00, 32'h0000_0280, 1'b1);
        get_result("t7", 3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
